// File: rtl/adder_pkg.sv
// Shared types and constants for the bit-serial add/subtract unit.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder slice used by the serial adder datapath.
module full_adder_bit (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = x ^ y ^ cin;
    assign cout = (x & y) | (x & cin) | (y & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial add/subtract: one operand bit per clock, LSB first, with a
// start/busy/done handshake and registered carry-out and signed overflow.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] ss;
    logic [WIDTH-1:0] ss_next;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             last;

    full_adder_bit u_fa (
        .x    (sa[0]),
        .y    (sb[0]),
        .cin  (c),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so the result is aligned after WIDTH shifts.
    assign ss_next = WIDTH'({fa_s, ss} >> 1);
    assign last    = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sa        <= '0;
            sb        <= '0;
            ss        <= '0;
            c         <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= (mode == MODE_SUB) ? ~b : b;
                        c     <= (mode == MODE_SUB);
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    ss  <= ss_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= fa_cout;
                    cnt <= cnt + CNT_W'(1);
                    // On the MSB slice, c is the carry into the sign bit.
                    if (last) begin
                        sum       <= ss_next;
                        carry_out <= fa_cout;
                        overflow  <= c ^ fa_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8 and WIDTH=1: arithmetic reference model
// compared every cycle, plus directed vectors with literal expectations.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic       mode8  = 1'b0;
    logic [7:0] a8     = 8'h00;
    logic [7:0] b8     = 8'h00;
    logic       busy8, done8, co8, ov8;
    logic [7:0] sum8;

    logic       start1 = 1'b0;
    logic       mode1  = 1'b0;
    logic [0:0] a1     = 1'b0;
    logic [0:0] b1     = 1'b0;
    logic       busy1, done1, co1, ov1;
    logic [0:0] sum1;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    bit checking = 1'b0;

    typedef struct packed {
        logic [63:0] sum;
        logic        co;
        logic        ov;
    } res_t;

    serial_adder #(.WIDTH(8)) u8 (
        .clk       (clk),
        .rst       (rst),
        .start     (start8),
        .mode      (mode8),
        .a         (a8),
        .b         (b8),
        .busy      (busy8),
        .done      (done8),
        .sum       (sum8),
        .carry_out (co8),
        .overflow  (ov8)
    );

    serial_adder #(.WIDTH(1)) u1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start1),
        .mode      (mode1),
        .a         (a1),
        .b         (b1),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .carry_out (co1),
        .overflow  (ov1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Reference arithmetic: signed overflow from the true signed result range.
    function automatic res_t refCalc(input int w, input longint unsigned a,
                                     input longint unsigned b, input logic sub);
        res_t            r;
        longint unsigned modulus;
        longint          sa, sb, t, half;
        modulus = 64'd1 << w;
        half    = longint'(modulus / 2);
        sa      = (a >= modulus / 2) ? longint'(a) - longint'(modulus) : longint'(a);
        sb      = (b >= modulus / 2) ? longint'(b) - longint'(modulus) : longint'(b);
        t       = sub ? sa - sb : sa + sb;
        r.ov    = (t < -half) || (t >= half);
        r.co    = sub ? (a >= b) : ((a + b) >= modulus);
        r.sum   = sub ? ((a + modulus - b) % modulus) : ((a + b) % modulus);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    // Cycle-level model: an accepted start yields a result WIDTH edges later.
    logic       m8Busy = 1'b0, m8Done = 1'b0, m8Co = 1'b0, m8Ov = 1'b0;
    logic [7:0] m8Sum  = 8'h00;
    int         m8Left = 0;
    res_t       m8Pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m8Busy <= 1'b0; m8Done <= 1'b0; m8Sum <= 8'h00;
            m8Co   <= 1'b0; m8Ov   <= 1'b0; m8Left <= 0;
        end else begin
            m8Done <= 1'b0;
            if (m8Busy) begin
                if (m8Left == 1) begin
                    m8Busy <= 1'b0;
                    m8Done <= 1'b1;
                    m8Sum  <= m8Pend.sum[7:0];
                    m8Co   <= m8Pend.co;
                    m8Ov   <= m8Pend.ov;
                end
                m8Left <= m8Left - 1;
            end else if (start8) begin
                m8Busy <= 1'b1;
                m8Left <= 8;
                m8Pend <= refCalc(8, 64'(a8), 64'(b8), mode8);
            end
        end
    end

    logic m1Busy = 1'b0, m1Done = 1'b0, m1Sum = 1'b0, m1Co = 1'b0, m1Ov = 1'b0;
    res_t m1Pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            m1Busy <= 1'b0; m1Done <= 1'b0; m1Sum <= 1'b0;
            m1Co   <= 1'b0; m1Ov   <= 1'b0;
        end else begin
            m1Done <= 1'b0;
            if (m1Busy) begin
                m1Busy <= 1'b0;
                m1Done <= 1'b1;
                m1Sum  <= m1Pend.sum[0];
                m1Co   <= m1Pend.co;
                m1Ov   <= m1Pend.ov;
            end else if (start1) begin
                m1Busy <= 1'b1;
                m1Pend <= refCalc(1, 64'(a1), 64'(b1), mode1);
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("busy8", 64'(busy8), 64'(m8Busy));
            checkOutput("done8", 64'(done8), 64'(m8Done));
            checkOutput("sum8",  64'(sum8),  64'(m8Sum));
            checkOutput("co8",   64'(co8),   64'(m8Co));
            checkOutput("ov8",   64'(ov8),   64'(m8Ov));
            checkOutput("busy1", 64'(busy1), 64'(m1Busy));
            checkOutput("done1", 64'(done1), 64'(m1Done));
            checkOutput("sum1",  64'(sum1),  64'(m1Sum));
            checkOutput("co1",   64'(co1),   64'(m1Co));
            checkOutput("ov1",   64'(ov1),   64'(m1Ov));
        end
    end

    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic m);
        a8 = a; b8 = b; mode8 = m; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic waitDone8(input string name, output int busyCnt);
        int t;
        busyCnt = 0;
        t = 0;
        while (!done8 && t < 20) begin
            if (busy8) busyCnt++;
            @(negedge clk);
            t++;
        end
        checkOutput({name, "_done"}, 64'(done8), 64'd1);
    endtask

    task automatic runOp(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic m, input logic [7:0] expSum, input logic expCo,
                         input logic expOv);
        int busyCnt;
        applyStimulus(a, b, m);
        waitDone8(name, busyCnt);
        checkOutput({name, "_busycycles"}, 64'(busyCnt), 64'd8);
        checkOutput({name, "_sum"}, 64'(sum8), 64'(expSum));
        checkOutput({name, "_co"},  64'(co8),  64'(expCo));
        checkOutput({name, "_ov"},  64'(ov8),  64'(expOv));
        @(negedge clk);
        checkOutput({name, "_pulse"}, 64'(done8), 64'd0);
    endtask

    task automatic applyStimulus1(input logic a, input logic b);
        a1 = a; b1 = b; mode1 = 1'b0; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
    endtask

    initial begin
        #1000000;
        failures++;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         busyCnt;
        int         t;
        bit         sawDone;
        logic [1:0] ab;
        logic [2:0] exp1 [4];
        exp1[0] = 3'b000;
        exp1[1] = 3'b100;
        exp1[2] = 3'b100;
        exp1[3] = 3'b011;

        @(negedge clk);
        checking = 1'b1;
        checkOutput("rst_busy8", 64'(busy8), 64'd0);
        checkOutput("rst_done8", 64'(done8), 64'd0);
        checkOutput("rst_sum8",  64'(sum8),  64'd0);
        checkOutput("rst_co8",   64'(co8),   64'd0);
        checkOutput("rst_ov8",   64'(ov8),   64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        runOp("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        runOp("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        runOp("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        runOp("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        runOp("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Start pulsed mid-run must not disturb the operation in flight.
        applyStimulus(8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        a8 = 8'h55; b8 = 8'h55; mode8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        waitDone8("midstart", busyCnt);
        checkOutput("midstart_sum", 64'(sum8), 64'h33);
        checkOutput("midstart_co",  64'(co8),  64'd0);
        repeat (12) @(negedge clk);
        checkOutput("midstart_idle", 64'(busy8), 64'd0);

        // Back-to-back: restart in the DONE cycle, old result held during the run.
        applyStimulus(8'h10, 8'h20, 1'b0);
        waitDone8("b2b_first", busyCnt);
        checkOutput("b2b_first_sum", 64'(sum8), 64'h30);
        a8 = 8'h03; b8 = 8'h04; mode8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        checkOutput("b2b_busyrise", 64'(busy8), 64'd1);
        busyCnt = 0;
        t = 0;
        while (!done8 && t < 20) begin
            if (busy8) busyCnt++;
            checkOutput("b2b_hold_sum", 64'(sum8), 64'h30);
            @(negedge clk);
            t++;
        end
        checkOutput("b2b_done", 64'(done8), 64'd1);
        checkOutput("b2b_busycycles", 64'(busyCnt), 64'd8);
        checkOutput("b2b_sum", 64'(sum8), 64'h07);

        // Reset in the middle of a run aborts it and clears the outputs.
        @(negedge clk);
        applyStimulus(8'h0F, 8'h01, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(busy8), 64'd0);
        checkOutput("abort_done", 64'(done8), 64'd0);
        checkOutput("abort_sum",  64'(sum8),  64'd0);
        checkOutput("abort_co",   64'(co8),   64'd0);
        checkOutput("abort_ov",   64'(ov8),   64'd0);
        sawDone = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) sawDone = 1'b1;
        end
        checkOutput("abort_quiet", 64'(sawDone), 64'd0);
        runOp("after_rst", 8'h22, 8'h11, 1'b0, 8'h33, 1'b0, 1'b0);

        // WIDTH=1 behaves like the original half adder in add mode.
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            applyStimulus1(ab[1], ab[0]);
            checkOutput("w1_busy", 64'(busy1), 64'd1);
            @(negedge clk);
            checkOutput("w1_done", 64'(done1), 64'd1);
            checkOutput("w1_sum",  64'(sum1),  64'(exp1[i][2]));
            checkOutput("w1_co",   64'(co1),   64'(exp1[i][1]));
            checkOutput("w1_ov",   64'(ov1),   64'(exp1[i][0]));
            @(negedge clk);
            checkOutput("w1_pulse", 64'(done1), 64'd0);
        end

        repeat (3) @(negedge clk);
        checking = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
